clkdiv_prog: RTL and testbench
==============================

CLKDIV_PROG -- requirements
Module: clkdiv_prog

Interface
REQ-001 Parameter: n, default 4, width of the division-ratio input; legal range n >= 1.
REQ-002 Single clock `in`; `reset` is synchronous and active-high.
REQ-003 Port: in  input  1  source clock; all state updates on its rising edge.
REQ-004 Port: reset  output  1  synchronous, active-high, one-`in`-cycle restart pulse; asserted in the cycle following each counter wrap.
REQ-005 Port: div  input  n  division setting, unsigned; the output half-period is div+1 `in` cycles.
REQ-006 Port: out  output  1  divided clock, registered, 50% duty cycle.

Function
REQ-007 The block SHALL hold an n-bit unsigned counter `cnt` and registers for `out` and `reset`; `out` and `reset` are driven directly from flops, with no combinational path from `div` to any output.
REQ-008 On each rising edge of `in`, if cnt >= div: cnt <= 0, out <= ~out, reset <= 1.
REQ-009 On each rising edge of `in`, if cnt < div: cnt <= cnt+1, out holds, reset <= 0.
REQ-010 Output frequency SHALL be f(in) / (2*(div+1)); high time and low time are each div+1 `in` cycles.
REQ-011 div = 0: `out` toggles on every rising edge (divide by 2), and `reset` remains continuously high.
REQ-012 div = 2^n-1: half-period 2^n cycles; `cnt` SHALL NOT overflow because the wrap occurs at cnt = 2^n-1.
REQ-013 `div` SHALL be sampled live every cycle, with no shadow register.
REQ-014 Increasing `div` mid-count extends the current half-period to the new div+1 cycles, counted from the last wrap.
REQ-015 Decreasing `div` to a value <= cnt forces a wrap on the next rising edge, so no half-period exceeds max(old, new)+1 cycles.
REQ-016 `out` SHALL toggle only on rising edges of `in`; `div` changes produce no glitches or runt pulses shorter than one `in` cycle.
REQ-017 `div` is assumed synchronous to `in`; no internal synchronizer is provided.

Reset
REQ-018 No reset input: all registers SHALL power up via initial values cnt=0, out=0, reset=0 (iCE40 flop init).
REQ-019 The first wrap SHALL occur on rising edge div+1 after configuration; `out` then goes 0->1, and `reset` goes high in the cycle that follows that edge.
REQ-020 `reset` is a status output only and SHALL NOT feed back into the block's own state.

Structure
REQ-021 No shared package is required; the block's only constant is the parameter n.
REQ-022 Single flat module, no sub-module: counter, comparator and toggle flop are inline.
REQ-023 The wrap comparison SHALL be implemented as unsigned cnt >= div at width n.

Verification
REQ-024 div=0 for 8 `in` cycles -> `out` toggles every cycle (period 2), `reset` constantly 1.
REQ-025 div=1 for 8 cycles -> `out` period 4 cycles (2 high, 2 low); `reset` high every 2nd cycle, coincident with each `out` edge.
REQ-026 div=2 for 12 cycles then div=3 for 16 cycles -> `out` periods 6 then 8 cycles; `reset` pulses every 3 then every 4 cycles.
REQ-027 div=4 with cnt=3, then div changed to 1 -> wrap and `out` toggle on the next rising edge; thereafter period 4 cycles.
REQ-028 div=2^n-1 (15 at n=4) -> `out` period 32 cycles; `cnt` reaches 15 and wraps to 0 with no overflow.
REQ-029 Power-up with div=3 -> out=0 and reset=0 for the first 3 cycles; the 4th rising edge sets out=1 and pulses `reset`.

Source files
------------

// File: rtl/clkdiv_prog.sv
// Programmable clock divider: out toggles every div+1 cycles of `in`, giving a 50% duty
// square wave at f(in)/(2*(div+1)), with a one-cycle `reset` status pulse after each wrap.
module clkdiv_prog #(
  parameter int n = 4
) (
  input  logic         in,
  input  logic [n-1:0] div,
  output logic         out,
  output logic         reset
);

  localparam logic [n-1:0] cnt_one = n'(1);

  // NOTE: no reset input exists, so every flop powers up from its declaration initializer
  // (FPGA flop init); these are not initial blocks and carry no simulation-only behaviour.
  logic [n-1:0] cnt_q   = '0;
  logic         out_q   = 1'b0;
  logic         reset_q = 1'b0;

  logic [n-1:0] cnt_d;
  logic         out_d;
  logic         reset_d;
  logic         wrap;

  // div is compared live; lowering it below cnt forces a wrap on the next edge
  // instead of letting the counter run all the way round.
  assign wrap = (cnt_q >= div);

  // NOTE: every output of this block gets a default first, so no latch can be inferred.
  always_comb begin
    cnt_d   = cnt_q + cnt_one;
    out_d   = out_q;
    reset_d = 1'b0;
    if (wrap) begin
      cnt_d   = '0;
      out_d   = ~out_q;
      reset_d = 1'b1;
    end
  end

  // NOTE: non-blocking assignments keep all three flops updating from the same pre-edge values.
  always_ff @(posedge in) begin
    cnt_q   <= cnt_d;
    out_q   <= out_d;
    reset_q <= reset_d;
  end

  assign out   = out_q;
  assign reset = reset_q;

endmodule

// File: tb/tb_clkdiv_prog.sv
// Directed bench for clkdiv_prog: hand-written out/reset sequences sampled on the falling
// edge after each rising edge of `in`, continuing from power-up without any reset.
module tb_clkdiv_prog;

  localparam int N = 4;

  logic         in = 1'b0;
  logic [N-1:0] div = 4'd3;
  logic         out;
  logic         reset;

  int n_checks = 0;
  int n_fails  = 0;

  clkdiv_prog #(.n(N)) dut (
    .in    (in),
    .div   (div),
    .out   (out),
    .reset (reset)
  );

  always #5 in = ~in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Apply div, then for each of `cycles` rising edges compare out/reset to the
  // expected character strings (index 0 = first edge after applying div).
  task automatic run(input string tag, input logic [N-1:0] d, input string exp_out,
                     input string exp_rst);
    div = d;
    for (int i = 0; i < exp_out.len(); i++) begin
      @(posedge in);
      @(negedge in);
      check($sformatf("%s out[%0d]", tag, i), {31'b0, out}, {31'b0, exp_out[i] == "1"});
      check($sformatf("%s rst[%0d]", tag, i), {31'b0, reset}, {31'b0, exp_rst[i] == "1"});
    end
  endtask

  initial begin
    #1;
    check("powerup out", {31'b0, out}, 32'd0);
    check("powerup rst", {31'b0, reset}, 32'd0);

    // Power-up with div=3: first wrap on the 4th edge.
    run("pwr_div3", 4'd3, "0001", "0001");
    // Divide by 2: toggle every edge, reset held high.
    run("div0", 4'd0, "01010101", "11111111");
    // Period 4.
    run("div1", 4'd1, "10011001", "01010101");
    // Period 6 then period 8.
    run("div2", 4'd2, "110001110001", "001001001001");
    run("div3", 4'd3, "1110000111100001", "0001000100010001");
    // div=4 up to cnt=3, then drop to 1: immediate wrap, then period 4.
    run("div4_pre", 4'd4, "111", "000");
    run("div4_to1", 4'd1, "0011001", "1010101");
    // Raise div mid-count: half-period stretches to 4 cycles from the last wrap.
    run("inc_pre", 4'd1, "1", "0");
    run("inc_to3", 4'd3, "110", "001");

    // Maximum div: half-period 16, counter peaks at 15 and wraps cleanly.
    div = 4'd15;
    for (int i = 0; i < 32; i++) begin
      @(posedge in);
      @(negedge in);
      check($sformatf("div15 out[%0d]", i), {31'b0, out}, {31'b0, (i >= 15 && i < 31)});
      check($sformatf("div15 rst[%0d]", i), {31'b0, reset}, {31'b0, (i == 15 || i == 31)});
      if (i == 14) check("div15 cnt peak", {28'b0, dut.cnt_q}, 32'd15);
      if (i == 15) check("div15 cnt wrap", {28'b0, dut.cnt_q}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
